// File: rtl/jtag_shift_engine.sv
// JTAG bit-bang master: runs whole SHIFT/TRST/RUNIDLE scan commands at a programmable
// TCK rate and returns the captured TDO vector over a valid/ready response channel.
module jtag_shift_engine #(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned LEN_W   = 6,
   parameter int unsigned DIV_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DIV_W-1:0]   cfg_half_period,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_tms,
   input  logic [MAX_LEN-1:0] cmd_tdi,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_tdo,
   output logic               rsp_undriven,
   output logic               rsp_err,
   output logic               jtag_TCK,
   output logic               jtag_TMS,
   output logic               jtag_TDI,
   output logic               jtag_TRSTn,
   input  logic               jtag_TDO_data,
   input  logic               jtag_TDO_driven
);

   localparam logic [1:0] OP_SHIFT   = 2'b00;
   localparam logic [1:0] OP_TRST    = 2'b01;
   localparam logic [1:0] OP_RUNIDLE = 2'b10;
   localparam logic [1:0] OP_RSVD    = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      TRST,
      RESP
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [DIV_W-1:0]   hm1_q, hm1_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [LEN_W-1:0]   bit_q, bit_d;
   logic               trst_hi_q, trst_hi_d;
   logic [MAX_LEN-1:0] tms_sh_q, tms_sh_d;
   logic [MAX_LEN-1:0] tdi_sh_q, tdi_sh_d;
   logic [MAX_LEN-1:0] mask_q, mask_d;

   logic               cmd_ready_d;
   logic               rsp_valid_d;
   logic [MAX_LEN-1:0] rsp_tdo_d;
   logic               rsp_undriven_d;
   logic               rsp_err_d;
   logic               tck_d, tms_d, tdi_d, trstn_d;

   logic               accept;
   logic [LEN_W-1:0]   len_clamped;
   logic [DIV_W-1:0]   h_m1;
   logic               last_bit;
   logic               div_done;

   assign accept      = cmd_valid && cmd_ready;
   assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
   assign h_m1        = (cfg_half_period == '0) ? '0 : cfg_half_period - DIV_W'(1);
   assign last_bit    = (bit_q == len_q - LEN_W'(1));
   assign div_done    = (div_q == '0);

   // Next-state and next-output logic; every register holds unless a branch overrides it.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      len_d          = len_q;
      hm1_d          = hm1_q;
      div_d          = div_q;
      bit_d          = bit_q;
      trst_hi_d      = trst_hi_q;
      tms_sh_d       = tms_sh_q;
      tdi_sh_d       = tdi_sh_q;
      mask_d         = mask_q;
      rsp_valid_d    = rsp_valid;
      rsp_tdo_d      = rsp_tdo;
      rsp_undriven_d = rsp_undriven;
      rsp_err_d      = rsp_err;
      tck_d          = jtag_TCK;
      tms_d          = jtag_TMS;
      tdi_d          = jtag_TDI;
      trstn_d        = jtag_TRSTn;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d           = cmd_op;
               len_d          = len_clamped;
               hm1_d          = h_m1;
               div_d          = h_m1;
               bit_d          = '0;
               trst_hi_d      = 1'b0;
               mask_d         = MAX_LEN'(1);
               rsp_tdo_d      = '0;
               rsp_undriven_d = 1'b0;
               rsp_err_d      = 1'b0;
               // Shift registers hold the bits after the one driven now; RUNIDLE drives zeros.
               tms_sh_d       = (cmd_op == OP_SHIFT) ? (cmd_tms >> 1) : '0;
               tdi_sh_d       = (cmd_op == OP_SHIFT) ? (cmd_tdi >> 1) : '0;
               if (cmd_op == OP_RSVD) begin
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else if (len_clamped == '0) begin
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else if (cmd_op == OP_TRST) begin
                  trstn_d = 1'b0;
                  tck_d   = 1'b0;
                  tms_d   = 1'b1;
                  state_d = TRST;
               end else begin
                  tck_d   = 1'b0;
                  tms_d   = (cmd_op == OP_SHIFT) ? cmd_tms[0] : 1'b0;
                  tdi_d   = (cmd_op == OP_SHIFT) ? cmd_tdi[0] : 1'b0;
                  state_d = SHIFT_LO;
               end
            end
         end

         SHIFT_LO: begin
            if (div_done) begin
               tck_d   = 1'b1;
               div_d   = hm1_q;
               state_d = SHIFT_HI;
               // TDO is captured on the clock that raises TCK.
               if (op_q == OP_SHIFT) begin
                  if (jtag_TDO_driven) begin
                     if (jtag_TDO_data) rsp_tdo_d = rsp_tdo | mask_q;
                  end else begin
                     rsp_undriven_d = 1'b1;
                  end
               end
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end

         SHIFT_HI: begin
            if (div_done) begin
               tck_d = 1'b0;
               if (last_bit) begin
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  bit_d    = bit_q + LEN_W'(1);
                  mask_d   = mask_q << 1;
                  tms_d    = tms_sh_q[0];
                  tdi_d    = tdi_sh_q[0];
                  tms_sh_d = tms_sh_q >> 1;
                  tdi_sh_d = tdi_sh_q >> 1;
                  div_d    = hm1_q;
                  state_d  = SHIFT_LO;
               end
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end

         TRST: begin
            // Two H-long halves per TCK period, counted without toggling TCK.
            if (div_done) begin
               div_d = hm1_q;
               if (!trst_hi_q) begin
                  trst_hi_d = 1'b1;
               end else if (last_bit) begin
                  trstn_d     = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  trst_hi_d = 1'b0;
                  bit_d     = bit_q + LEN_W'(1);
               end
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      cmd_ready_d = (state_d == IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         op_q         <= OP_SHIFT;
         len_q        <= '0;
         hm1_q        <= '0;
         div_q        <= '0;
         bit_q        <= '0;
         trst_hi_q    <= 1'b0;
         tms_sh_q     <= '0;
         tdi_sh_q     <= '0;
         mask_q       <= '0;
         cmd_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_tdo      <= '0;
         rsp_undriven <= 1'b0;
         rsp_err      <= 1'b0;
         jtag_TCK     <= 1'b0;
         jtag_TMS     <= 1'b1;
         jtag_TDI     <= 1'b0;
         jtag_TRSTn   <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         len_q        <= len_d;
         hm1_q        <= hm1_d;
         div_q        <= div_d;
         bit_q        <= bit_d;
         trst_hi_q    <= trst_hi_d;
         tms_sh_q     <= tms_sh_d;
         tdi_sh_q     <= tdi_sh_d;
         mask_q       <= mask_d;
         cmd_ready    <= cmd_ready_d;
         rsp_valid    <= rsp_valid_d;
         rsp_tdo      <= rsp_tdo_d;
         rsp_undriven <= rsp_undriven_d;
         rsp_err      <= rsp_err_d;
         jtag_TCK     <= tck_d;
         jtag_TMS     <= tms_d;
         jtag_TDI     <= tdi_d;
         jtag_TRSTn   <= trstn_d;
      end
   end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Bench for jtag_shift_engine: directed and random scan commands checked against a
// per-command expectation computed from the command itself plus a pin monitor.
module tb_jtag_shift_engine;

   localparam int MAX_LEN = 32;
   localparam int LEN_W   = 6;
   localparam int DIV_W   = 8;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [DIV_W-1:0]   cfg_half_period = '0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [1:0]         cmd_op = '0;
   logic [LEN_W-1:0]   cmd_len = '0;
   logic [MAX_LEN-1:0] cmd_tms = '0;
   logic [MAX_LEN-1:0] cmd_tdi = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [MAX_LEN-1:0] rsp_tdo;
   logic               rsp_undriven;
   logic               rsp_err;
   logic               jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
   logic               jtag_TDO_data, jtag_TDO_driven;

   always #5 clock = ~clock;

   // TDO source: loopback of TDI or a per-bit pattern, indexed by TCK rises seen so far.
   logic        loopback  = 1'b0;
   logic [63:0] tdo_pat   = '0;
   logic [63:0] undrv_pat = '0;
   logic [5:0]  rises     = '0;
   assign jtag_TDO_data   = loopback ? jtag_TDI : tdo_pat[rises];
   assign jtag_TDO_driven = ~undrv_pat[rises];

   jtag_shift_engine dut (
      .clock(clock), .reset(reset), .cfg_half_period(cfg_half_period),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
      .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_tdo(rsp_tdo), .rsp_undriven(rsp_undriven), .rsp_err(rsp_err),
      .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
      .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Pin monitor, sampled on the falling clock edge.
   logic        mon_en = 1'b0;
   logic [1:0]  mon_op = '0;
   int          mon_h = 1;
   logic [63:0] exp_tms = '0;
   logic [63:0] exp_tdi = '0;
   int          hi_cyc = 0, trst_low = 0, pin_bad = 0, period_bad = 0;
   int          cyc = 0, last_rise = 0;
   logic        prev_tck = 1'b0;

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (mon_en) begin
         if (jtag_TCK) hi_cyc = hi_cyc + 1;
         if (!jtag_TRSTn) begin
            trst_low = trst_low + 1;
            if (jtag_TCK || !jtag_TMS) pin_bad = pin_bad + 1;
         end
         if (mon_op == 2'b10 && (jtag_TMS || jtag_TDI)) pin_bad = pin_bad + 1;
         if (jtag_TCK && !prev_tck) begin
            if (jtag_TMS !== exp_tms[rises] || jtag_TDI !== exp_tdi[rises]) pin_bad = pin_bad + 1;
            if (rises != 0 && (cyc - last_rise) != 2 * mon_h) period_bad = period_bad + 1;
            last_rise = cyc;
            rises     = rises + 6'd1;
         end
      end
      prev_tck = jtag_TCK;
   end

   // Issue one command, compare the response and pin activity, then consume the response.
   task automatic run_cmd(input logic [1:0] op, input int len_raw, input int cfg,
                          input logic [31:0] tms, input logic [31:0] tdi,
                          input logic lb, input int hold);
      int          len, h, lat, k;
      logic [63:0] e_tdo;
      logic        e_und, e_err;
      int          e_lat, e_rise, e_hi, e_trst;

      len    = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
      h      = (cfg == 0) ? 1 : cfg;
      e_tdo  = '0;
      e_und  = 1'b0;
      e_err  = (op == 2'b11);
      e_lat  = 0;
      e_rise = 0;
      e_hi   = 0;
      e_trst = 0;
      if (op != 2'b11 && len > 0) begin
         e_lat = 2 * h * len;
         if (op == 2'b01) e_trst = 2 * h * len;
         else begin
            e_rise = len;
            e_hi   = h * len;
         end
         if (op == 2'b00) begin
            for (int i = 0; i < len; i++) begin
               if (undrv_pat[i]) e_und = 1'b1;
               else e_tdo[i] = lb ? tdi[i] : tdo_pat[i];
            end
         end
      end

      k = 0;
      while (!cmd_ready && k < 100) begin
         @(posedge clock); #1;
         k++;
      end
      check("cmd_ready_wait", 64'(cmd_ready), 64'(1));

      loopback        = lb;
      cmd_op          = op;
      cmd_len         = LEN_W'(len_raw);
      cmd_tms         = tms;
      cmd_tdi         = tdi;
      cfg_half_period = DIV_W'(cfg);
      cmd_valid       = 1'b1;
      mon_op          = op;
      mon_h           = h;
      exp_tms         = (op == 2'b00) ? {32'b0, tms} : 64'b0;
      exp_tdi         = (op == 2'b00) ? {32'b0, tdi} : 64'b0;
      rises           = '0;
      hi_cyc          = 0;
      trst_low        = 0;
      pin_bad         = 0;
      period_bad      = 0;
      @(posedge clock); #1;
      cmd_valid       = 1'b0;
      cfg_half_period = DIV_W'($urandom);
      cmd_tms         = $urandom;
      cmd_tdi         = $urandom;
      mon_en          = 1'b1;

      lat = 0;
      while (!rsp_valid && lat < 3000) begin
         @(posedge clock); #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(e_lat));
      check("rsp_tdo", 64'(rsp_tdo), e_tdo);
      check("rsp_undriven", 64'(rsp_undriven), 64'(e_und));
      check("rsp_err", 64'(rsp_err), 64'(e_err));
      check("tck_rises", 64'(rises), 64'(e_rise));
      check("tck_high_cycles", 64'(hi_cyc), 64'(e_hi));
      check("trstn_low_cycles", 64'(trst_low), 64'(e_trst));
      check("tck_period_errs", 64'(period_bad), 64'(0));
      check("pin_value_errs", 64'(pin_bad), 64'(0));
      check("tck_idle", 64'({jtag_TCK, jtag_TRSTn}), 64'(2'b01));
      check("ready_in_resp", 64'(cmd_ready), 64'(0));

      for (int c = 0; c < hold; c++) begin
         @(posedge clock); #1;
         check("hold_tdo", 64'(rsp_tdo), e_tdo);
         check("hold_valid_ready", 64'({rsp_valid, cmd_ready}), 64'(2'b10));
      end

      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      mon_en    = 1'b0;
      check("rsp_drop", 64'(rsp_valid), 64'(0));
      check("ready_after_bubble", 64'(cmd_ready), 64'(1));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      logic [1:0] op;

      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
      check("reset_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}), 64'(4'b0101));
      check("reset_rsp", 64'({rsp_valid, rsp_undriven, rsp_err}), 64'(0));
      check("reset_rsp_tdo", 64'(rsp_tdo), 64'(0));
      reset = 1'b0;
      @(posedge clock); #1;
      check("ready_after_reset", 64'(cmd_ready), 64'(1));

      // SHIFT 8 bits with TDI looped back onto TDO.
      undrv_pat = '0;
      run_cmd(2'b00, 8, 2, 32'h00, 32'hA5, 1'b1, 0);
      // Full-length SHIFT, TDO undriven on bit 3 only.
      tdo_pat   = {$urandom, $urandom};
      undrv_pat = 64'h8;
      run_cmd(2'b00, MAX_LEN, 1, $urandom, $urandom, 1'b0, 0);
      undrv_pat = '0;
      // TRST for 4 periods at H=3.
      run_cmd(2'b01, 4, 3, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 0);
      // RUNIDLE with a zero half-period.
      run_cmd(2'b10, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      // Reserved opcode.
      run_cmd(2'b11, 7, 2, 32'hFF, 32'hFF, 1'b0, 0);
      // Response held off for 10 cycles, then a zero-length SHIFT and a clamped length.
      run_cmd(2'b00, 5, 1, 32'h15, 32'h0A, 1'b1, 10);
      run_cmd(2'b00, 0, 4, 32'hFF, 32'hFF, 1'b0, 0);
      run_cmd(2'b00, 40, 1, $urandom, $urandom, 1'b1, 0);

      // Reset in the middle of bit 3 of an 8-bit SHIFT.
      loopback        = 1'b1;
      cmd_op          = 2'b00;
      cmd_len         = LEN_W'(8);
      cmd_tms         = 32'hFF;
      cmd_tdi         = 32'h5A;
      cfg_half_period = DIV_W'(2);
      mon_op          = 2'b00;
      mon_h           = 2;
      exp_tms         = 64'hFF;
      exp_tdi         = 64'h5A;
      rises           = '0;
      cmd_valid       = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      mon_en    = 1'b1;
      k = 0;
      while (rises < 6'd3 && k < 200) begin
         @(posedge clock); #1;
         k++;
      end
      check("mid_rises_reached", 64'(rises), 64'(3));
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      mon_en = 1'b0;
      check("abort_pins", 64'({jtag_TCK, jtag_TMS, jtag_TRSTn}), 64'(3'b011));
      check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
      check("abort_cmd_ready", 64'(cmd_ready), 64'(0));
      reset = 1'b0;
      @(posedge clock); #1;
      check("abort_ready_after", 64'(cmd_ready), 64'(1));
      repeat (5) @(posedge clock);
      #1;
      check("abort_no_rsp", 64'({rsp_valid, jtag_TCK}), 64'(0));

      // Randomized commands.
      for (int t = 0; t < 40; t++) begin
         op        = 2'($urandom_range(0, 3));
         tdo_pat   = {$urandom, $urandom};
         undrv_pat = ($urandom_range(0, 2) == 0) ? (64'(1) << $urandom_range(0, 31)) : 64'b0;
         run_cmd(op, $urandom_range(0, 40), $urandom_range(0, 4), $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
